// File: rtl/radix_4_ntt_operand_collector_if.sv
// Bundles the coefficient stream, the twiddle ROM port and the PE-side group bus.
// master = collector side, slave = the environment (source, ROM and PE).
// Optional range_err signal is present only when RADIX4_RANGE_CHECK_EN is defined.
interface radix_4_ntt_operand_collector_if #(
  parameter int N        = 17,
  parameter int LOG_POLY = 8
);
  localparam int AW = (LOG_POLY > 2) ? (LOG_POLY - 2) : 1;

  logic          inv;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [AW-1:0] tf_addr;
  logic          tf_rd;
  logic [N-1:0]  tf_rdata0;
  logic [N-1:0]  tf_rdata1;
  logic [N-1:0]  tf_rdata2;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  a0;
  logic [N-1:0]  a1;
  logic [N-1:0]  a2;
  logic [N-1:0]  a3;
  logic [N-1:0]  tf0;
  logic [N-1:0]  tf1;
  logic [N-1:0]  tf2;
  logic          out_inv;
  logic          out_last;
`ifdef RADIX4_RANGE_CHECK_EN
  logic          range_err;
`endif

  modport master (
    input  inv, in_valid, in_data, tf_rdata0, tf_rdata1, tf_rdata2, out_ready,
    output in_ready, tf_addr, tf_rd, out_valid, a0, a1, a2, a3, tf0, tf1, tf2,
           out_inv, out_last
`ifdef RADIX4_RANGE_CHECK_EN
    , output range_err
`endif
  );

  modport slave (
    output inv, in_valid, in_data, tf_rdata0, tf_rdata1, tf_rdata2, out_ready,
    input  in_ready, tf_addr, tf_rd, out_valid, a0, a1, a2, a3, tf0, tf1, tf2,
           out_inv, out_last
`ifdef RADIX4_RANGE_CHECK_EN
    , input range_err
`endif
  );
endinterface

// File: rtl/radix_4_ntt_operand_collector.sv
// Packs a serial coefficient stream into radix-4 groups, fetches 3 twiddles, presents to the PE.
// Latency: out_valid rises 2 cycles after the 4th coefficient handshake; 1 group per 6 cycles.
// Backpressure: in_ready drops while a group is fetched/presented; group held until out_ready.
// Optional RADIX4_RANGE_CHECK_EN adds a sticky range_err flag for coefficients >= Q.
module radix_4_ntt_operand_collector #(
  parameter int N        = 17,
  parameter int LOG_POLY = 8,
  parameter int Q        = 65537
) (
  input logic                              clk,
  input logic                              rst_n,
  radix_4_ntt_operand_collector_if.master  bus
);
  localparam int AW = (LOG_POLY > 2) ? (LOG_POLY - 2) : 1;
  localparam logic [AW-1:0] LAST_GRP = AW'((1 << (LOG_POLY - 2)) - 1);

  localparam logic [1:0] S_FILL    = 2'd0;
  localparam logic [1:0] S_TF_WAIT = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_fill_cnt;
  logic [AW-1:0] r_grp;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_inv;
  logic [N-1:0]  r_a0, r_a1, r_a2, r_a3;
  logic [N-1:0]  r_tf0, r_tf1, r_tf2;

  logic w_acc;
  logic w_grp_done;
  logic w_out_hs;

  // in_ready is only ever high in FILL, so it doubles as the state qualifier
  assign w_acc      = r_in_ready & bus.in_valid;
  assign w_grp_done = w_acc & (r_fill_cnt == 2'd3);
  assign w_out_hs   = r_out_valid & bus.out_ready;

  // The ROM read is issued in the same cycle as the 4th handshake so data lands during TF_WAIT
  assign bus.tf_rd     = w_grp_done;
  assign bus.tf_addr   = r_grp;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_inv   = r_inv;
  assign bus.a0        = r_a0;
  assign bus.a1        = r_a1;
  assign bus.a2        = r_a2;
  assign bus.a3        = r_a3;
  assign bus.tf0       = r_tf0;
  assign bus.tf1       = r_tf1;
  assign bus.tf2       = r_tf2;

  // Control FSM plus the coefficient/twiddle capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_fill_cnt  <= 2'd0;
      r_grp       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_inv       <= 1'b0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_a3        <= '0;
      r_tf0       <= '0;
      r_tf1       <= '0;
      r_tf2       <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          // in_ready comes up one cycle after reset release and stays up until a group completes
          r_in_ready <= ~w_grp_done;
          if (w_acc) begin
            case (r_fill_cnt)
              2'd0:    r_a0 <= bus.in_data;
              2'd1:    r_a1 <= bus.in_data;
              2'd2:    r_a2 <= bus.in_data;
              default: r_a3 <= bus.in_data;
            endcase
            // Mode is frozen at the very first coefficient of each polynomial
            if ((r_fill_cnt == 2'd0) && (r_grp == '0)) begin
              r_inv <= bus.inv;
            end
            r_fill_cnt <= r_fill_cnt + 2'd1;
            if (r_fill_cnt == 2'd3) begin
              r_state <= S_TF_WAIT;
            end
          end
        end
        S_TF_WAIT: begin
          r_tf0       <= bus.tf_rdata0;
          r_tf1       <= bus.tf_rdata1;
          r_tf2       <= bus.tf_rdata2;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_grp == LAST_GRP);
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_out_hs) begin
            r_grp       <= (r_grp == LAST_GRP) ? '0 : r_grp + 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        default: begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef RADIX4_RANGE_CHECK_EN
  localparam logic [N:0] Q_EXT = Q[N:0];
  logic w_over;
  logic r_range_err;

  assign w_over        = w_acc & ({1'b0, bus.in_data} >= Q_EXT);
  assign bus.range_err = r_range_err;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_range_err <= 1'b0;
    end else if (w_over) begin
      r_range_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_radix_4_ntt_operand_collector.sv
// Self-checking bench for radix_4_ntt_operand_collector (N=17, LOG_POLY=4).
// Directed table of groups with hand-computed expectations, plus a random phase
// checked against a coefficient-count based reference model.
module tb_radix_4_ntt_operand_collector;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  radix_4_ntt_operand_collector_if #(.N(17), .LOG_POLY(4)) bus ();

  radix_4_ntt_operand_collector #(.N(17), .LOG_POLY(4), .Q(65537)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [16:0] rom(input logic [1:0] ad, input int k);
    return 17'((k + 1) * 100 + int'(ad) * 1000);
  endfunction

  // Synchronous twiddle ROM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.tf_rd) begin
      bus.tf_rdata0 <= rom(bus.tf_addr, 0);
      bus.tf_rdata1 <= rom(bus.tf_addr, 1);
      bus.tf_rdata2 <= rom(bus.tf_addr, 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: group contents follow from the running count of accepted coefficients
  typedef struct packed {
    logic [3:0][16:0] a;
    logic [1:0]       grp;
    logic             inv;
  } grp_t;

  grp_t             exp_q[$];
  grp_t             m_g;
  grp_t             m_o;
  logic [3:0][16:0] m_buf;
  int               m_n = 0;
  logic             m_inv = 1'b0;
  logic             m_hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_n = 0;
      exp_q.delete();
    end else begin
      m_hs = bus.in_valid && bus.in_ready;
      chk("m_tf_rd", 32'(bus.tf_rd), 32'(m_hs && (m_n % 4 == 3)));
      chk("m_rdy_vld_excl", 32'(bus.in_ready && bus.out_valid), 32'd0);
      if (m_hs) begin
        if (m_n % 16 == 0) m_inv = bus.inv;
        m_buf[m_n % 4] = bus.in_data;
        if (m_n % 4 == 3) begin
          m_g.a   = m_buf;
          m_g.grp = 2'((m_n / 4) % 4);
          m_g.inv = m_inv;
          exp_q.push_back(m_g);
          chk("m_tf_addr", 32'(bus.tf_addr), 32'(m_g.grp));
        end
        m_n++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("m_unexpected_group", 32'd1, 32'd0);
        end else begin
          m_o = exp_q.pop_front();
          chk("m_a0", 32'(bus.a0), 32'(m_o.a[0]));
          chk("m_a1", 32'(bus.a1), 32'(m_o.a[1]));
          chk("m_a2", 32'(bus.a2), 32'(m_o.a[2]));
          chk("m_a3", 32'(bus.a3), 32'(m_o.a[3]));
          chk("m_tf0", 32'(bus.tf0), 32'(rom(m_o.grp, 0)));
          chk("m_tf1", 32'(bus.tf1), 32'(rom(m_o.grp, 1)));
          chk("m_tf2", 32'(bus.tf2), 32'(rom(m_o.grp, 2)));
          chk("m_inv", 32'(bus.out_inv), 32'(m_o.inv));
          chk("m_last", 32'(bus.out_last), 32'(m_o.grp == 2'd3));
        end
      end
    end
  end

  // Offer one coefficient and wait (bounded) for it to be accepted
  task automatic send(input logic [16:0] d, input logic iv, input int chk_addr);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inv      = iv;
    #1;
    while (!bus.in_ready && g < 50) begin
      tick();
      #1;
      g++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 32'(bus.in_ready), 32'd1);
    end
    if (chk_addr >= 0) begin
      chk("tf_rd_pulse", 32'(bus.tf_rd), 32'd1);
      chk("tf_addr", 32'(bus.tf_addr), 32'(chk_addr));
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0][16:0] c;
    logic [3:0]       iv;
    logic [1:0]       addr;
    logic [2:0][16:0] t;
    logic             last;
    logic             einv;
  } vec_t;

  vec_t vt[9];

  task automatic chk_group(input vec_t v, input string tag);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_a0"}, 32'(bus.a0), 32'(v.c[0]));
    chk({tag, "_a1"}, 32'(bus.a1), 32'(v.c[1]));
    chk({tag, "_a2"}, 32'(bus.a2), 32'(v.c[2]));
    chk({tag, "_a3"}, 32'(bus.a3), 32'(v.c[3]));
    chk({tag, "_tf0"}, 32'(bus.tf0), 32'(v.t[0]));
    chk({tag, "_tf1"}, 32'(bus.tf1), 32'(v.t[1]));
    chk({tag, "_tf2"}, 32'(bus.tf2), 32'(v.t[2]));
    chk({tag, "_inv"}, 32'(bus.out_inv), 32'(v.einv));
    chk({tag, "_last"}, 32'(bus.out_last), 32'(v.last));
  endtask

  initial begin
    //        coefficients                        inv per coef  addr  twiddles                last einv
    vt[0] = '{c:'{17'd8, 17'd7, 17'd6, 17'd5},         iv:4'b0000, addr:2'd0, t:'{17'd300, 17'd200, 17'd100},    last:1'b0, einv:1'b0};
    vt[1] = '{c:'{17'd23, 17'd22, 17'd21, 17'd20},     iv:4'b0000, addr:2'd1, t:'{17'd1300, 17'd1200, 17'd1100}, last:1'b0, einv:1'b0};
    vt[2] = '{c:'{17'd33, 17'd32, 17'd31, 17'd30},     iv:4'b1111, addr:2'd2, t:'{17'd2300, 17'd2200, 17'd2100}, last:1'b0, einv:1'b0};
    vt[3] = '{c:'{17'd43, 17'd42, 17'd41, 17'd40},     iv:4'b0000, addr:2'd3, t:'{17'd3300, 17'd3200, 17'd3100}, last:1'b1, einv:1'b0};
    vt[4] = '{c:'{17'd53, 17'd52, 17'd51, 17'd50},     iv:4'b0101, addr:2'd0, t:'{17'd300, 17'd200, 17'd100},    last:1'b0, einv:1'b1};
    vt[5] = '{c:'{17'd63, 17'd62, 17'd61, 17'd60},     iv:4'b0000, addr:2'd1, t:'{17'd1300, 17'd1200, 17'd1100}, last:1'b0, einv:1'b1};
    vt[6] = '{c:'{17'd73, 17'd72, 17'd71, 17'd70},     iv:4'b1111, addr:2'd2, t:'{17'd2300, 17'd2200, 17'd2100}, last:1'b0, einv:1'b1};
    vt[7] = '{c:'{17'd83, 17'd82, 17'd81, 17'd80},     iv:4'b0000, addr:2'd3, t:'{17'd3300, 17'd3200, 17'd3100}, last:1'b1, einv:1'b1};
    vt[8] = '{c:'{17'd65535, 17'd1, 17'd0, 17'd65536}, iv:4'b1110, addr:2'd0, t:'{17'd300, 17'd200, 17'd100},    last:1'b0, einv:1'b0};

    // Reset with in_valid asserted: nothing is accepted, everything clears
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 17'd3;
    bus.inv       = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_inv", 32'(bus.out_inv), 32'd0);
    chk("rst_tf_rd", 32'(bus.tf_rd), 32'd0);
    chk("rst_tf_addr", 32'(bus.tf_addr), 32'd0);
    chk("rst_data", 32'(bus.a0 | bus.a1 | bus.a2 | bus.a3 | bus.tf0 | bus.tf1 | bus.tf2), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed groups: two full polynomials plus the start of a third
    for (int i = 0; i < 9; i++) begin
      if (i == 0) bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        send(vt[i].c[k], vt[i].iv[k], (k == 3) ? int'(vt[i].addr) : -1);
      end
      #1;
      chk($sformatf("g%0d_lat1_vld", i), 32'(bus.out_valid), 32'd0);
      tick();
      #1;
      chk_group(vt[i], $sformatf("g%0d", i));
      if (i == 0) begin
        // Held group under backpressure: stable, and stream input not consumed
        for (int w = 0; w < 10; w++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 17'd999;
          tick();
          #1;
          chk_group(vt[0], $sformatf("bp%0d", w));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
      end
      tick();
      #1;
      chk($sformatf("g%0d_done_vld", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("g%0d_done_rdy", i), 32'(bus.in_ready), 32'd1);
    end

    // Reset in the middle of a group discards the partial fill
    rst_n = 1'b1;
    tick();
    send(17'd1, 1'b0, -1);
    send(17'd2, 1'b0, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(17'd9, 1'b0, -1);
    send(17'd10, 1'b0, -1);
    send(17'd11, 1'b0, -1);
    send(17'd12, 1'b0, 0);
    tick();
    #1;
    chk_group('{c:'{17'd12, 17'd11, 17'd10, 17'd9}, iv:4'b0000, addr:2'd0,
                t:'{17'd300, 17'd200, 17'd100}, last:1'b0, einv:1'b0}, "mid_rst");
    tick();

    // Random traffic on both sides against the reference model
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = 17'($urandom_range(0, 65536));
      bus.inv       = 1'($urandom % 2);
      bus.out_ready = ($urandom % 3) != 0;
      tick();
    end

`ifdef RADIX4_RANGE_CHECK_EN
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("range_err_clear", 32'(bus.range_err), 32'd0);
    send(17'd65537, 1'b0, -1);
    #1;
    chk("range_err_set", 32'(bus.range_err), 32'd1);
    tick();
    tick();
    #1;
    chk("range_err_sticky", 32'(bus.range_err), 32'd1);
`endif

    // Drain: any completed group must have been delivered
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_vld", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/radix_4_ntt_operand_collector.md
Name: radix_4_ntt_operand_collector

Overview:
Upstream feeder for the radix-4 NTT/INTT butterfly PE cell. Accepts a serial coefficient stream (one coefficient per handshake) and packs each run of 4 into a butterfly group (a0..a3). Fetches that group's three twiddles from an external synchronous twiddle ROM and presents group, twiddles and mode to the PE through a valid/ready handshake. Also tracks group position within the polynomial.

Parameters:
N, 17, coefficient/twiddle width in bits
LOG_POLY, 8, log2 of coefficients per polynomial; minimum 2
Q, 65537, modulus; used only by the optional range check

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
inv  in  1  mode select: 0 = NTT, 1 = INTT; sampled per polynomial
in_valid  in  1  input coefficient valid
in_ready  out  1  collector can accept a coefficient
in_data  in  N  input coefficient
tf_addr  out  LOG_POLY-2  twiddle ROM address (group index)
tf_rd  out  1  twiddle ROM read strobe
tf_rdata0 / tf_rdata1 / tf_rdata2  in  N each  ROM data, valid exactly 1 cycle after tf_rd
out_valid  out  1  group valid to PE
out_ready  in  1  PE accepts group
a0 / a1 / a2 / a3  out  N each  packed coefficients
tf0 / tf1 / tf2  out  N each  captured twiddles
out_inv  out  1  mode latched for this polynomial
out_last  out  1  high with the final group of a polynomial

Behaviour:
- Reset (rst_n low at clk edge): state FILL, fill count 0, group index 0. All of the following are 0: in_ready, tf_rd, out_valid, out_last, out_inv, a0..a3, tf0..tf2, tf_addr. Reset mid-operation discards any partial or presented group.
- FILL: in_ready = 1. On each in_valid & in_ready, write in_data to slot a[fill_cnt] and increment fill_cnt (2-bit).
  - On the first accepted coefficient of a polynomial (group index 0, fill_cnt 0), latch inv into out_inv.
  - On the 4th accepted coefficient (fill_cnt 3): fill_cnt wraps to 0; pulse tf_rd for 1 cycle with tf_addr = group index; go to TF_WAIT.
- TF_WAIT (1 cycle): in_ready = 0. Capture tf_rdata0..2 into tf0..tf2, then go to PRESENT.
- PRESENT: in_ready = 0; out_valid = 1. a0..a3, tf0..tf2, out_inv and out_last are held stable until the handshake completes.
  - out_last = 1 iff group index == 2^(LOG_POLY-2) - 1.
  - On out_valid & out_ready: group index increments (wraps to 0 after the last group); go to FILL.
- in_ready is never high in the same cycle as out_valid. Latency from the 4th coefficient handshake to out_valid high is 2 cycles. Sustained throughput is 1 group per 6 cycles when out_ready is held high.
- out_ready high outside PRESENT: ignored. in_valid high outside FILL: ignored, and the coefficient is not consumed.
- inv changes mid-polynomial: no effect until the next polynomial's first coefficient.
- No arithmetic on data. Coefficients pass through unmodified; they are expected to be already reduced below Q.

Optional Feature:
Macro RADIX4_RANGE_CHECK_EN.
- Defined: adds output port range_err (1 bit). It is sticky and set in the cycle after any accepted in_data >= Q. It is cleared only by reset. Data flow is unaffected.
- Undefined: the port and its comparator are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all data outputs 0. After release, in_ready=1.
- Single group: stream 5,6,7,8 with inv=0 and ROM returning 100,200,300 for address 0 -> tf_rd pulses with tf_addr=0. Two cycles after the 4th handshake: out_valid=1, a0..a3=5,6,7,8, tf0..tf2=100,200,300, out_inv=0, out_last=0.
- Backpressure: hold out_ready=0 for 10 cycles in PRESENT with in_valid=1 -> outputs stable, in_ready=0, no coefficient consumed. Drop to out_ready=1 -> one handshake, then in_ready=1 next cycle.
- Polynomial wrap (LOG_POLY=4): stream 16 coefficients with out_ready=1 -> tf_addr sequence 0,1,2,3; out_last high only on group 3. The next polynomial restarts at tf_addr=0.
- Mode latch: inv=1 at the first coefficient, toggled to 0 mid-polynomial -> out_inv=1 for all 4 groups. The next polynomial started with inv=0 gives out_inv=0.
- Mid-operation reset: assert rst_n=0 after 2 of 4 coefficients, then stream 9,10,11,12 -> group presents a0..a3=9,10,11,12 with tf_addr=0. With RADIX4_RANGE_CHECK_EN, in_data=65537 sets range_err=1 and it stays set.
